traffic_phase_sched: RTL and testbench

TRAFFIC_PHASE_SCHED -- requirements
Module: traffic_phase_sched

---
 rtl/traffic_phase_sched.sv | 191 +++++++++++++++++++
 tb/tb_traffic_phase_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_sched.sv
// Purpose : nine-phase traffic intersection sequencer with request latches and round-robin protected-turn service.
// Latency : all outputs registered; lights, walk and phase change in the same cycle as the state register; count shows remaining ticks.
// Backpress: none -- sensors are level inputs latched every cycle; requests are held until their serving phase is entered.
// Ports   : clk, reset (sync, active-high), sensors[4:0] (left main, left cross, cross traffic, walk main, walk cross);
//           main_lights/cross_lights {red,yellow,green,yellow_arrow,green_arrow}, walk[1:0], count[3:0], phase[3:0].
module traffic_phase_sched #(
   parameter int TICK_DIV = 50000000,
   parameter int GREEN_T  = 5,
   parameter int ARROW_T  = 4,
   parameter int YELLOW_T = 3,
   parameter int ALLRED_T = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] sensors,
   output logic [4:0] main_lights,
   output logic [4:0] cross_lights,
   output logic [1:0] walk,
   output logic [3:0] count,
   output logic [3:0] phase
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   // One-hot state bit positions; the bit index is also the phase code.
   localparam int S_MAIN_GO       = 0;
   localparam int S_MAIN_YEL      = 1;
   localparam int S_ALL_RED       = 2;
   localparam int S_MAIN_ARW      = 3;
   localparam int S_MAIN_ARW_YEL  = 4;
   localparam int S_CROSS_ARW     = 5;
   localparam int S_CROSS_ARW_YEL = 6;
   localparam int S_CROSS_GO      = 7;
   localparam int S_CROSS_YEL     = 8;

   localparam logic [8:0] ALL_RED_OH = 9'(1) << S_ALL_RED;

   localparam logic [4:0] L_RED = 5'b10000;
   localparam logic [4:0] L_YEL = 5'b01000;
   localparam logic [4:0] L_GRN = 5'b00100;
   localparam logic [4:0] L_YAR = 5'b00010;
   localparam logic [4:0] L_GAR = 5'b00001;

   logic [8:0]    state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    count_q, count_d;
   logic [4:0]    req_q, req_d;
   logic [1:0]    rr_q, rr_d;
   logic [4:0]    main_lights_q, main_lights_d;
   logic [4:0]    cross_lights_q, cross_lights_d;
   logic [1:0]    walk_q, walk_d;
   logic [3:0]    phase_q, phase_d;

   logic       tick, expire, entry, load, found;
   logic [2:0] cls;
   logic [1:0] gcls;
   logic [4:0] clr;
   int         c;

   function automatic logic [3:0] dur_of(input logic [8:0] s);
      logic [3:0] d;
      d = 4'(ALLRED_T);
      if (s[S_MAIN_GO] | s[S_CROSS_GO])                                    d = 4'(GREEN_T);
      if (s[S_MAIN_ARW] | s[S_CROSS_ARW])                                  d = 4'(ARROW_T);
      if (s[S_MAIN_YEL] | s[S_MAIN_ARW_YEL] | s[S_CROSS_ARW_YEL] | s[S_CROSS_YEL]) d = 4'(YELLOW_T);
      return d;
   endfunction

   // State register (plus all other flops).
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ALL_RED_OH;
         presc_q        <= '0;
         count_q        <= 4'(ALLRED_T);
         req_q          <= '0;
         rr_q           <= 2'd0;
         main_lights_q  <= L_RED;
         cross_lights_q <= L_RED;
         walk_q         <= 2'b00;
         phase_q        <= 4'(S_ALL_RED);
      end else begin
         state_q        <= state_d;
         presc_q        <= presc_d;
         count_q        <= count_d;
         req_q          <= req_d;
         rr_q           <= rr_d;
         main_lights_q  <= main_lights_d;
         cross_lights_q <= cross_lights_d;
         walk_q         <= walk_d;
         phase_q        <= phase_d;
      end
   end

   // Next-state, timing and request logic.
   always_comb begin
      tick    = (presc_q == PW'(TICK_DIV - 1));
      expire  = tick && (count_q == 4'd1);
      state_d = state_q;
      rr_d    = rr_q;
      cls     = {req_q[2] | req_q[4], req_q[1], req_q[0]};
      found   = 1'b0;
      gcls    = 2'd0;
      c       = 0;

      // First active class at or after the round-robin pointer.
      for (int k = 0; k < 3; k++) begin
         c = (int'(rr_q) + k) % 3;
         if (!found && cls[c]) begin
            found = 1'b1;
            gcls  = 2'(c);
         end
      end

      if (!$onehot(state_q)) begin
         state_d = ALL_RED_OH;
      end else if (expire) begin
         if (state_q[S_MAIN_GO]) begin
            // With nothing pending, stay in MAIN_GO; load below reloads the dwell.
            if (|cls) state_d = 9'(1) << S_MAIN_YEL;
         end else if (state_q[S_MAIN_YEL] | state_q[S_MAIN_ARW_YEL] |
                      state_q[S_CROSS_ARW_YEL] | state_q[S_CROSS_YEL]) begin
            state_d = ALL_RED_OH;
         end else if (state_q[S_MAIN_ARW]) begin
            state_d = 9'(1) << S_MAIN_ARW_YEL;
         end else if (state_q[S_CROSS_ARW]) begin
            state_d = 9'(1) << S_CROSS_ARW_YEL;
         end else if (state_q[S_CROSS_GO]) begin
            state_d = 9'(1) << S_CROSS_YEL;
         end else begin
            if (!found)            state_d = 9'(1) << S_MAIN_GO;
            else if (gcls == 2'd0) state_d = 9'(1) << S_MAIN_ARW;
            else if (gcls == 2'd1) state_d = 9'(1) << S_CROSS_ARW;
            else                   state_d = 9'(1) << S_CROSS_GO;
            if (found) rr_d = (gcls == 2'd2) ? 2'd0 : gcls + 2'd1;
         end
      end

      entry = (state_d != state_q);
      load  = expire || entry;

      if (load) begin
         count_d = dur_of(state_d);
         presc_d = '0;
      end else if (tick) begin
         count_d = count_q - 4'd1;
         presc_d = '0;
      end else begin
         count_d = count_q;
         presc_d = presc_q + PW'(1);
      end

      // Clearing on entry takes priority over a sensor set in the same cycle.
      clr = '0;
      if (entry) begin
         clr[0] = state_d[S_MAIN_ARW];
         clr[1] = state_d[S_CROSS_ARW];
         clr[2] = state_d[S_CROSS_GO];
         clr[3] = state_d[S_MAIN_GO];
         clr[4] = state_d[S_CROSS_GO];
      end
      req_d = (req_q | sensors) & ~clr;
   end

   // Output decode from the next state so the registered outputs align with state_q.
   always_comb begin
      main_lights_d  = L_RED;
      cross_lights_d = L_RED;
      phase_d        = 4'(S_ALL_RED);
      walk_d         = walk_q;
      if (state_d[S_MAIN_GO])       main_lights_d  = L_GRN;
      if (state_d[S_MAIN_YEL])      main_lights_d  = L_YEL;
      if (state_d[S_MAIN_ARW])      main_lights_d  = L_GAR;
      if (state_d[S_MAIN_ARW_YEL])  main_lights_d  = L_YAR;
      if (state_d[S_CROSS_ARW])     cross_lights_d = L_GAR;
      if (state_d[S_CROSS_ARW_YEL]) cross_lights_d = L_YAR;
      if (state_d[S_CROSS_GO])      cross_lights_d = L_GRN;
      if (state_d[S_CROSS_YEL])     cross_lights_d = L_YEL;
      for (int i = 0; i < 9; i++) begin
         if (state_d[i]) phase_d = 4'(i);
      end
      // Walk is decided once at phase entry and held for the whole phase.
      if (entry) walk_d = {state_d[S_CROSS_GO] & req_q[4], state_d[S_MAIN_GO] & req_q[3]};
   end

   assign main_lights  = main_lights_q;
   assign cross_lights = cross_lights_q;
   assign walk         = walk_q;
   assign count        = count_q;
   assign phase        = phase_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Purpose : randomized + directed scoreboard bench for traffic_phase_sched with a cycle-count reference model.
// Latency : expected outputs are queued before each posedge and compared just after it.
// Backpress: none; the monitor pops one expectation per clock.
module tb_traffic_phase_sched;

   localparam int DIV = 4;
   localparam int GT  = 5;
   localparam int AT  = 4;
   localparam int YT  = 3;
   localparam int RT  = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] sensors = 5'b0;
   logic [4:0] main_lights, cross_lights;
   logic [1:0] walk;
   logic [3:0] count, phase;

   traffic_phase_sched #(.TICK_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .sensors(sensors),
      .main_lights(main_lights), .cross_lights(cross_lights),
      .walk(walk), .count(count), .phase(phase)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] m;
      logic [4:0] c;
      logic [1:0] w;
      logic [3:0] cnt;
      logic [3:0] ph;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model: phase code, cycles left in phase, request bits, rr class, walk.
   int       m_ph;
   int       m_left;
   bit [4:0] m_req;
   int       m_rr;
   bit [1:0] m_walk;

   function automatic int dur(input int p);
      case (p)
         0, 7:       return GT;
         3, 5:       return AT;
         1, 4, 6, 8: return YT;
         default:    return RT;
      endcase
   endfunction

   task automatic model_step(input bit rst, input bit [4:0] s);
      int       nxt;
      bit [4:0] old_req;
      bit [2:0] act;
      exp_t     e;
      if (rst) begin
         m_ph = 2; m_left = RT * DIV; m_req = '0; m_rr = 0; m_walk = 2'b00;
      end else begin
         old_req = m_req;
         nxt = m_ph;
         act = {old_req[2] | old_req[4], old_req[1], old_req[0]};
         if (m_left == 1) begin
            case (m_ph)
               0: nxt = (act != 0) ? 1 : 0;
               1, 4, 6, 8: nxt = 2;
               3: nxt = 4;
               5: nxt = 6;
               7: nxt = 8;
               default: begin
                  nxt = 0;
                  for (int k = 0; k < 3; k++) begin
                     int cl;
                     cl = (m_rr + k) % 3;
                     if (nxt == 0 && act[cl]) begin
                        nxt  = (cl == 0) ? 3 : (cl == 1) ? 5 : 7;
                        m_rr = (cl + 1) % 3;
                     end
                  end
               end
            endcase
            m_left = dur(nxt) * DIV;
         end else begin
            m_left = m_left - 1;
         end
         m_req = m_req | s;
         if (nxt != m_ph) begin
            if (nxt == 3) m_req[0] = 1'b0;
            if (nxt == 5) m_req[1] = 1'b0;
            if (nxt == 7) begin m_req[2] = 1'b0; m_req[4] = 1'b0; end
            if (nxt == 0) m_req[3] = 1'b0;
            m_walk = (nxt == 0) ? {1'b0, old_req[3]} : (nxt == 7) ? {old_req[4], 1'b0} : 2'b00;
         end
         m_ph = nxt;
      end
      e.m = 5'b10000;
      e.c = 5'b10000;
      case (m_ph)
         0: e.m = 5'b00100;
         1: e.m = 5'b01000;
         3: e.m = 5'b00001;
         4: e.m = 5'b00010;
         5: e.c = 5'b00001;
         6: e.c = 5'b00010;
         7: e.c = 5'b00100;
         8: e.c = 5'b01000;
         default: ;
      endcase
      e.w   = m_walk;
      e.cnt = 4'((m_left + DIV - 1) / DIV);
      e.ph  = 4'(m_ph);
      exp_q.push_back(e);
   endtask

   task automatic step(input bit rst, input bit [4:0] s);
      @(negedge clk);
      reset   = rst;
      sensors = s;
      model_step(rst, s);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 5'b0);
   endtask

   // Monitor: one expectation per posedge, sampled 1 time unit after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({main_lights, cross_lights, walk, count, phase} !== e) begin
               miscompares++;
               $display("FAIL outputs t=%0t: got m=%b c=%b w=%b cnt=%0d ph=%0d, want m=%b c=%b w=%b cnt=%0d ph=%0d",
                        $time, main_lights, cross_lights, walk, count, phase, e.m, e.c, e.w, e.cnt, e.ph);
            end
            vectors++;
            if (!main_lights[4] && !cross_lights[4]) begin
               miscompares++;
               $display("FAIL conflict t=%0t: main=%b cross=%b both non-red", $time, main_lights, cross_lights);
            end
            vectors++;
            if (!$onehot(main_lights) || !$onehot(cross_lights)) begin
               miscompares++;
               $display("FAIL onehot t=%0t: main=%b cross=%b", $time, main_lights, cross_lights);
            end
         end
      end
   end

   initial begin
      int guard;
      bit [4:0] s;
      step(1'b1, 5'b0);
      step(1'b1, 5'b0);
      idle(80);                       // idle: ALL_RED then MAIN_GO cycling
      step(1'b0, 5'b00001); idle(120);  // main left turn
      step(1'b0, 5'b00111); idle(250);  // all three classes, round robin
      step(1'b0, 5'b10000); idle(150);  // cross walk
      step(1'b0, 5'b01000); idle(30);   // main walk request, then something to cycle phases
      step(1'b0, 5'b00001); idle(200);
      step(1'b0, 5'b00010);           // reset during CROSS_ARW
      guard = 0;
      while (m_ph != 5 && guard < 400) begin
         idle(1);
         guard++;
      end
      if (m_ph != 5) begin
         miscompares++;
         $display("FAIL reach_cross_arw: model phase %0d, want 5", m_ph);
      end
      idle(3);
      step(1'b1, 5'b0);
      idle(50);
      for (int i = 0; i < 4000; i++) begin
         for (int b = 0; b < 5; b++) s[b] = ($urandom_range(0, 49) == 0);
         step($urandom_range(0, 1499) == 0, s);
      end
      @(negedge clk);
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
